// File: rtl/multi_dataflow_in_gate.sv
// multi_dataflow_in_gate
//   Length-gated elastic input stage in front of the engine's inStream0 sink.
//   A job forwards exactly len_i words from the streamer to the engine
//   through a DEPTH-entry FIFO. Words beyond the job length are held off.
//   done_o pulses once the last word has left toward the engine. cnt_o reports
//   the number of words delivered in the current or last job.
//
// Optional feature (compile-time macro MULTI_DATAFLOW_IN_GATE_STRB_CHECK_EN):
//   defined   -> any accepted word whose strobe is not all-ones sets the
//                sticky err_o (cleared only by clear_i or reset). The word is
//                still forwarded unchanged.
//   undefined -> err_o is tied to 0 and no check logic exists.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous soft clear
//   start_i, len_i           job start pulse (IDLE only) and job length
//   in_valid_i/in_ready_o    upstream handshake, in_data_i/in_strb_i payload
//   out_valid_o/out_ready_i  downstream handshake, out_data_o/out_strb_o payload
//   busy_o                   job in progress (RUN or DRAIN)
//   done_o                   one-cycle pulse at job end
//   cnt_o                    words delivered downstream
//   err_o                    sticky strobe error
module multi_dataflow_in_gate #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [DATA_WIDTH/8-1:0] out_strb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LEN_WIDTH-1:0]    cnt_o,
  output logic                    err_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_in;
  logic [LEN_WIDTH-1:0]  cnt_out;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [STRB_W-1:0]     mem_strb [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_in;
  logic last_out;

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == '0);

  // Push is blocked whenever the FIFO is full, even if a pop happens in the
  // same cycle: there is no fall-through path from input to output.
  assign in_ready_o  = (state == S_RUN) && !full && (cnt_in < len_q);
  assign out_valid_o = !empty;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Final accepted word of the job, and the pop that empties the FIFO while
  // draining (no pushes can occur in DRAIN, so occupancy 1 means last word).
  assign last_in  = push && (cnt_in == len_q - LEN_ONE);
  assign last_out = pop && (occ == OCC_ONE);

  // Head of the FIFO drives the output; it reads as zero while empty so the
  // outputs are all zero after reset or clear.
  assign out_data_o = empty ? '0 : mem_data[rd_ptr];
  assign out_strb_o = empty ? '0 : mem_strb[rd_ptr];

  assign busy_o = (state != S_IDLE);
  assign done_o = done_q;
  assign cnt_o  = cnt_out;

  // FIFO storage: payload only, never reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data_i;
      mem_strb[wr_ptr] <= in_strb_i;
    end
  end

  // Control: FSM, pointers, occupancy and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt_in  <= '0;
      cnt_out <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt_in  <= '0;
      cnt_out <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        cnt_in <= cnt_in + LEN_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        cnt_out <= cnt_out + LEN_ONE;
      end

      if (push && !pop) begin
        occ <= occ + OCC_ONE;
      end else if (!push && pop) begin
        occ <= occ - OCC_ONE;
      end

      case (state)
        S_IDLE: begin
          // FIFO is empty and input is held off here, so the counter clears
          // never collide with the increments above.
          if (start_i) begin
            len_q   <= len_i;
            cnt_in  <= '0;
            cnt_out <= '0;
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (last_in) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_out) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MULTI_DATAFLOW_IN_GATE_STRB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (push && (in_strb_i != {STRB_W{1'b1}})) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_dataflow_in_gate.sv
// Testbench for multi_dataflow_in_gate: directed job scenarios plus randomized
// jobs, checked every cycle against a queue-based behavioural model.
module tb_multi_dataflow_in_gate;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 16;
  localparam int SW    = DW / 8;

  logic          clk_i       = 1'b0;
  logic          rst_ni      = 1'b0;
  logic          clear_i     = 1'b0;
  logic          start_i     = 1'b0;
  logic [LW-1:0] len_i       = '0;
  logic          in_valid_i  = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i   = '0;
  logic [SW-1:0] in_strb_i   = '1;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [SW-1:0] out_strb_o;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] cnt_o;
  logic          err_o;

  multi_dataflow_in_gate #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_strb_i  (in_strb_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_strb_o (out_strb_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int shown = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Behavioural model: a job accepts len words, words sit in a queue of at
  // most DEPTH entries, the job ends when all len words have left the queue.
  logic [DW+SW-1:0] m_q[$];
  int m_len = 0;
  int m_acc = 0;
  int m_cnt = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  bit m_pushed = 1'b0;
  bit mr, mv, mpush, mpop, mwas;

  function automatic bit m_ready();
    return m_active && (m_q.size() < DEPTH) && (m_acc < m_len);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      m_q.delete();
      m_active = 1'b0;
      m_len    = 0;
      m_acc    = 0;
      m_cnt    = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_pushed = 1'b0;
    end else begin
      mr    = m_ready();
      mv    = (m_q.size() != 0);
      mpush = in_valid_i && mr;
      mpop  = mv && out_ready_i;
      mwas  = m_active;
      m_done = 1'b0;
      if (mpop) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (mpush) begin
        m_q.push_back({in_strb_i, in_data_i});
        m_acc++;
`ifdef MULTI_DATAFLOW_IN_GATE_STRB_CHECK_EN
        if (in_strb_i != {SW{1'b1}}) m_err = 1'b1;
`endif
      end
      m_pushed = mpush;
      if (mwas && (m_acc == m_len) && (m_q.size() == 0)) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else if (!mwas && start_i) begin
        m_len = int'(len_i);
        m_acc = 0;
        m_cnt = 0;
        if (m_len == 0) m_done = 1'b1;
        else            m_active = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("in_ready", in_ready_o, m_ready());
      check("out_valid", out_valid_o, (m_q.size() != 0));
      if (m_q.size() != 0 && out_valid_o) begin
        check("out_data", out_data_o, m_q[0][DW-1:0]);
        check("out_strb", out_strb_o, m_q[0][DW+SW-1:DW]);
      end
      check("busy", busy_o, m_active);
      check("done", done_o, m_done);
      check("cnt", cnt_o, m_cnt);
      check("err", err_o, m_err);
    end
  end

  // Streamer and sink: valid is chosen independently of ready, and a word is
  // held until the model says it was accepted.
  int src_rate = 100;
  int rdy_rate = 100;
  int bad_idx  = -1;
  int cur_idx  = 0;
  bit strb_rand = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (m_pushed || !in_valid_i) begin
      if ($urandom_range(99) < src_rate) begin
        cur_idx++;
        in_valid_i = 1'b1;
        in_data_i  = $urandom;
        if (cur_idx == bad_idx)                         in_strb_i = 4'b0111;
        else if (strb_rand && $urandom_range(3) == 0)   in_strb_i = SW'($urandom);
        else                                            in_strb_i = '1;
      end else begin
        in_valid_i = 1'b0;
      end
    end
    out_ready_i = ($urandom_range(99) < rdy_rate);
  end

  // Event monitor used by the literal checks.
  int cyc_n = 0, acc_n = 0, pop_n = 0, done_n = 0, busy_n = 0;
  int last_acc = 0, last_pop = 0, done_cyc = 0;

  always @(posedge clk_i) begin
    cyc_n++;
    if (in_valid_i && in_ready_o) begin acc_n++; last_acc = cyc_n; end
    if (out_valid_o && out_ready_i) begin pop_n++; last_pop = cyc_n; end
    if (done_o) begin done_n++; done_cyc = cyc_n; end
    if (busy_o) busy_n++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start_job(input int len);
    len_i   = LW'(len);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_n == base && k < 2000) begin
      step(1);
      k++;
    end
    check("done_seen", (done_n > base), 1);
  endtask

  int a0, p0, d0, b0, s, k, len;
  int act;

  initial begin
    // Reset state
    rst_ni = 1'b0;
    step(3);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_err", err_o, 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    step(2);

    // len=8, always valid/ready: accepts s+1..s+8, pops s+2..s+9, done at s+10
    src_rate = 100;
    rdy_rate = 100;
    step(2);
    a0 = acc_n; p0 = pop_n; d0 = done_n;
    start_job(8);
    s = cyc_n;
    wait_done(d0);
    check("t1_acc", acc_n - a0, 8);
    check("t1_pop", pop_n - p0, 8);
    check("t1_last_acc", last_acc, s + 8);
    check("t1_last_pop", last_pop, s + 9);
    check("t1_done_cyc", done_cyc, s + 10);
    check("t1_cnt", cnt_o, 8);

    // len=6 with a stalled sink: only DEPTH words accepted
    rdy_rate = 0;
    step(2);
    a0 = acc_n; p0 = pop_n; d0 = done_n;
    start_job(6);
    step(10);
    check("t2_acc_stall", acc_n - a0, 4);
    check("t2_ready_low", in_ready_o, 0);
    check("t2_out_valid", out_valid_o, 1);
    rdy_rate = 100;
    wait_done(d0);
    check("t2_pop", pop_n - p0, 6);
    check("t2_cnt", cnt_o, 6);

    // len=0: done next cycle, never busy, nothing accepted
    step(2);
    a0 = acc_n; b0 = busy_n; d0 = done_n;
    start_job(0);
    check("t3_done", done_o, 1);
    check("t3_busy", busy_o, 0);
    check("t3_ready", in_ready_o, 0);
    step(3);
    check("t3_busy_cycles", busy_n - b0, 0);
    check("t3_acc", acc_n - a0, 0);
    check("t3_done_count", done_n - d0, 1);

    // len=5 with a streamer that keeps offering more words
    rdy_rate = 50;
    step(2);
    a0 = acc_n; d0 = done_n;
    start_job(5);
    wait_done(d0);
    step(4);
    check("t4_acc", acc_n - a0, 5);
    check("t4_cnt", cnt_o, 5);
    check("t4_ready", in_ready_o, 0);

    // clear during RUN after 3 of 10 words, then a normal len=2 job
    rdy_rate = 100;
    step(2);
    a0 = acc_n; d0 = done_n;
    start_job(10);
    k = 0;
    while ((acc_n - a0) < 3 && k < 50) begin
      step(1);
      k++;
    end
    check("t5_three_acc", acc_n - a0, 3);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("t5_out_valid", out_valid_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_cnt", cnt_o, 0);
    check("t5_done", done_o, 0);
    step(3);
    check("t5_no_done", done_n - d0, 0);
    d0 = done_n;
    start_job(2);
    wait_done(d0);
    check("t5_cnt2", cnt_o, 2);

`ifdef MULTI_DATAFLOW_IN_GATE_STRB_CHECK_EN
    // third word of a len=5 job carries a partial strobe
    step(2);
    check("t6_err_before", err_o, 0);
    bad_idx = in_valid_i ? cur_idx + 2 : cur_idx + 3;
    d0 = done_n;
    start_job(5);
    wait_done(d0);
    check("t6_err_set", err_o, 1);
    check("t6_cnt", cnt_o, 5);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("t6_err_clr", err_o, 0);
`endif

    // randomized jobs with occasional clear or asynchronous reset mid-job
    strb_rand = 1'b1;
    for (int j = 0; j < 40; j++) begin
      src_rate = $urandom_range(30, 100);
      rdy_rate = $urandom_range(30, 100);
      step(1);
      len = $urandom_range(0, 12);
      act = $urandom_range(0, 9);
      d0  = done_n;
      start_job(len);
      if (act == 0) begin
        step($urandom_range(0, 8));
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
      end else if (act == 1) begin
        step($urandom_range(0, 8));
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_valid", out_valid_o, 0);
        check("arst_cnt", cnt_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1);
      end else begin
        wait_done(d0);
      end
    end

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
